lcd_rx: RTL and testbench

Receiving end of the HD44780 4-bit LCD bus that our `lcd` driver produces. It watches RS/E/D4–D7 (plus the LED backlight line) and reconstructs the display state: it assembles nibbles into bytes, decodes the HD44780 command subset the driver uses, and writes character data into a 2×16 DDRAM shadow. A registered read port exposes the shadow. It serves as an on-chip loopback checker for the name-badge and as the reference responder in the driver's bench.

---
 rtl/lcd_rx_if.sv | 16 +
 rtl/lcd_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_lcd_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_rx_if.sv
// HD44780 4-bit LCD bus as seen on the wire: register select, enable strobe,
// the upper data nibble and the backlight request line.
interface lcd_rx_if;
    logic RS;
    logic E;
    logic D4;
    logic D5;
    logic D6;
    logic D7;
    logic LED;

    // Driver side (the lcd controller or a bench).
    modport master (output RS, E, D4, D5, D6, D7, LED);
    // Receiver side (lcd_rx).
    modport slave  (input  RS, E, D4, D5, D6, D7, LED);
endinterface

// File: rtl/lcd_rx.sv
// lcd_rx: receiving end of the HD44780 4-bit bus. Synchronises the bus,
// detects E falling edges, pairs nibbles into bytes, decodes the command
// subset used by our driver and keeps a 2x16 DDRAM shadow with a registered
// read port. Clear sweeps one entry per cycle; strobes during a sweep are
// dropped and flagged in a sticky overrun bit.
module lcd_rx (
    input  logic        CLK,
    input  logic        RST,
    lcd_rx_if.slave     bus,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        display_on,
    output logic        four_bit,
    output logic        backlight,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        BOOT8  = 2'd0,
        NIB_HI = 2'd1,
        NIB_LO = 2'd2,
        CLEAR  = 2'd3
    } mode_e;

    // Synchroniser layout: {LED, RS, E, D7, D6, D5, D4}
    logic [6:0] sync1_q, sync2_q;
    logic       e_prev_q;
    logic       fall_q;
    logic [4:0] cap_q;              // {RS, D7..D4} captured on the E fall

    mode_e      state_q, state_d;
    mode_e      ret_q, ret_d;       // mode to resume after a clear sweep
    mode_e      next_mode_s;
    logic [3:0] hi_q, hi_d;
    logic       hi_rs_q, hi_rs_d;
    logic [6:0] addr_q, addr_d;
    logic       inc_q, inc_d;
    logic       disp_q, disp_d;
    logic       four_q, four_d;
    logic       busy_q, busy_d;
    logic       ovr_q, ovr_d;
    logic [4:0] clr_idx_q, clr_idx_d;
    logic [7:0] rd_data_q;

    logic       exec_s;
    logic [7:0] byte_s;
    logic       rs_s;
    logic       we_s;
    logic [4:0] wa_s;
    logic [7:0] wd_s;

    logic [7:0] mem_q [0:31];

    // Two-flop synchronisers plus registered E-fall detect and bus capture.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q  <= 7'd0;
            sync2_q  <= 7'd0;
            e_prev_q <= 1'b0;
            fall_q   <= 1'b0;
            cap_q    <= 5'd0;
        end else begin
            sync1_q  <= {bus.LED, bus.RS, bus.E, bus.D7, bus.D6, bus.D5, bus.D4};
            sync2_q  <= sync1_q;
            e_prev_q <= sync2_q[4];
            fall_q   <= e_prev_q & ~sync2_q[4];
            cap_q    <= {sync2_q[5], sync2_q[3:0]};
        end
    end

    // Mode FSM, nibble pairing, command decode and DDRAM write selection.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        hi_d        = hi_q;
        hi_rs_d     = hi_rs_q;
        addr_d      = addr_q;
        inc_d       = inc_q;
        disp_d      = disp_q;
        four_d      = four_q;
        ovr_d       = ovr_q;
        clr_idx_d   = clr_idx_q;
        exec_s      = 1'b0;
        byte_s      = 8'h00;
        rs_s        = 1'b0;
        next_mode_s = state_q;
        we_s        = 1'b0;
        wa_s        = 5'd0;
        wd_s        = 8'h00;

        case (state_q)
            BOOT8: begin
                if (fall_q) begin
                    exec_s      = 1'b1;
                    byte_s      = {cap_q[3:0], 4'h0};
                    rs_s        = cap_q[4];
                    next_mode_s = BOOT8;
                end else begin
                    exec_s = 1'b0;
                end
            end
            NIB_HI: begin
                if (fall_q) begin
                    hi_d    = cap_q[3:0];
                    hi_rs_d = cap_q[4];
                    state_d = NIB_LO;
                end else begin
                    state_d = NIB_HI;
                end
            end
            NIB_LO: begin
                if (fall_q) begin
                    exec_s      = 1'b1;
                    byte_s      = {hi_q, cap_q[3:0]};
                    rs_s        = hi_rs_q;
                    next_mode_s = NIB_HI;
                end else begin
                    exec_s = 1'b0;
                end
            end
            CLEAR: begin
                we_s      = 1'b1;
                wa_s      = clr_idx_q;
                wd_s      = 8'h20;
                clr_idx_d = clr_idx_q + 5'd1;
                if (clr_idx_q == 5'd31) begin
                    state_d = ret_q;
                end else begin
                    state_d = CLEAR;
                end
                // Strobes during the sweep are dropped; phase does not advance.
                if (fall_q) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
            end
            default: begin
                state_d = BOOT8;
            end
        endcase

        if (exec_s) begin
            state_d = next_mode_s;
            if (rs_s) begin
                we_s   = 1'b1;
                wa_s   = {addr_q[6], addr_q[3:0]};
                wd_s   = byte_s;
                addr_d = inc_q ? (addr_q + 7'd1) : (addr_q - 7'd1);
            end else if (byte_s[7]) begin
                addr_d = byte_s[6:0];
            end else if (byte_s[6]) begin
                addr_d = addr_q;            // CGRAM address: not modelled
            end else if (byte_s[5]) begin
                if (!byte_s[4]) begin
                    four_d  = 1'b1;
                    state_d = NIB_HI;
                end else begin
                    state_d = BOOT8;
                end
            end else if (byte_s[4]) begin
                addr_d = addr_q;            // cursor/display shift: not modelled
            end else if (byte_s[3]) begin
                disp_d = byte_s[2];
            end else if (byte_s[2]) begin
                inc_d = byte_s[1];
            end else if (byte_s[1]) begin
                addr_d = 7'd0;
            end else if (byte_s[0]) begin
                addr_d    = 7'd0;
                inc_d     = 1'b1;
                clr_idx_d = 5'd0;
                ret_d     = next_mode_s;
                state_d   = CLEAR;
            end else begin
                addr_d = addr_q;
            end
        end else begin
            exec_s = 1'b0;
        end

        busy_d = (state_d == CLEAR);
    end

    // Control/status registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= BOOT8;
            ret_q     <= BOOT8;
            hi_q      <= 4'd0;
            hi_rs_q   <= 1'b0;
            addr_q    <= 7'd0;
            inc_q     <= 1'b1;
            disp_q    <= 1'b0;
            four_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            clr_idx_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            hi_q      <= hi_d;
            hi_rs_q   <= hi_rs_d;
            addr_q    <= addr_d;
            inc_q     <= inc_d;
            disp_q    <= disp_d;
            four_q    <= four_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // DDRAM shadow storage; intentionally not reset (defined by a clear).
    always_ff @(posedge CLK) begin
        if (we_s) begin
            mem_q[wa_s] <= wd_s;
        end
    end

    // Registered read port; a same-cycle write returns the old contents.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data    = rd_data_q;
    assign display_on = disp_q;
    assign four_bit   = four_q;
    assign backlight  = sync2_q[6];
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_lcd_rx.sv
// Directed bench for lcd_rx: drives the 4-bit bus with slow strobes and
// checks status outputs and DDRAM contents against hand-computed values.
module tb_lcd_rx;
    logic       CLK;
    logic       RST;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       display_on, four_bit, backlight, busy, overrun;
    int         errors;
    int         checks;
    int         cnt;

    lcd_rx_if bus ();

    lcd_rx dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus.slave),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .display_on (display_on),
        .four_bit   (four_bit),
        .backlight  (backlight),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One E pulse: data set up, E high 4 cycles, E low and hold 4 cycles.
    // On return the effect of the strobe is already visible.
    task automatic strobe(input logic rs, input logic [3:0] nib);
        bus.RS = rs;
        {bus.D7, bus.D6, bus.D5, bus.D4} = nib;
        tick(1);
        bus.E = 1'b1;
        tick(4);
        bus.E = 1'b0;
        tick(4);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        strobe(rs, b[7:4]);
        strobe(rs, b[3:0]);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick(1);
            n++;
        end
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
        rd_addr = a;
        tick(1);
        check(tag, rd_data, exp);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        RST     = 1'b0;
        rd_addr = 5'd0;
        bus.RS  = 1'b0;
        bus.E   = 1'b0;
        bus.D4  = 1'b0;
        bus.D5  = 1'b0;
        bus.D6  = 1'b0;
        bus.D7  = 1'b0;
        bus.LED = 1'b0;
        tick(3);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_display_on", {7'd0, display_on}, 8'h00);
        check("rst_four_bit", {7'd0, four_bit}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_overrun", {7'd0, overrun}, 8'h00);
        RST = 1'b1;
        tick(2);

        // Backlight: two-cycle synchroniser delay.
        bus.LED = 1'b1;
        tick(1);
        check("backlight_1cyc", {7'd0, backlight}, 8'h00);
        tick(1);
        check("backlight_2cyc", {7'd0, backlight}, 8'h01);

        // Init sequence in BOOT8.
        strobe(1'b0, 4'h3);
        strobe(1'b0, 4'h3);
        strobe(1'b0, 4'h3);
        check("init_after_3x3", {7'd0, four_bit}, 8'h00);
        strobe(1'b0, 4'h2);
        check("init_after_2", {7'd0, four_bit}, 8'h01);
        send_byte(1'b0, 8'h28);
        check("init_after_28", {7'd0, four_bit}, 8'h01);

        // Clear and text.
        send_byte(1'b0, 8'h01);
        check("clear_busy_hi", {7'd0, busy}, 8'h01);
        wait_idle(cnt);
        check("clear_busy_len", cnt[7:0], 8'd32);
        send_byte(1'b1, 8'h48);
        send_byte(1'b1, 8'h69);
        read_chk("text_0", 5'd0, 8'h48);
        read_chk("text_1", 5'd1, 8'h69);
        for (int i = 2; i < 32; i++) begin
            read_chk("blank", i[4:0], 8'h20);
        end

        // Line 2 and 7-bit address wrap.
        send_byte(1'b0, 8'hC0);
        send_byte(1'b1, 8'h41);
        read_chk("line2_16", 5'd16, 8'h41);
        send_byte(1'b0, 8'hFF);
        send_byte(1'b1, 8'h42);
        send_byte(1'b1, 8'h43);
        read_chk("wrap_31", 5'd31, 8'h42);
        read_chk("wrap_0", 5'd0, 8'h43);

        // Decrement mode.
        send_byte(1'b0, 8'h04);
        send_byte(1'b0, 8'h85);
        send_byte(1'b1, 8'h31);
        send_byte(1'b1, 8'h32);
        read_chk("dec_5", 5'd5, 8'h31);
        read_chk("dec_4", 5'd4, 8'h32);
        read_chk("dec_6_untouched", 5'd6, 8'h20);

        // Overrun: strobe during a clear sweep.
        send_byte(1'b0, 8'h01);
        check("ovr_before", {7'd0, overrun}, 8'h00);
        tick(1);
        strobe(1'b0, 4'h7);
        check("ovr_busy_still", {7'd0, busy}, 8'h01);
        check("ovr_set", {7'd0, overrun}, 8'h01);
        wait_idle(cnt);
        check("ovr_idle", {7'd0, busy}, 8'h00);
        check("disp_before", {7'd0, display_on}, 8'h00);
        send_byte(1'b0, 8'h0C);
        check("disp_on", {7'd0, display_on}, 8'h01);
        read_chk("clr2_0", 5'd0, 8'h20);
        read_chk("clr2_5", 5'd5, 8'h20);
        read_chk("clr2_31", 5'd31, 8'h20);
        // Clear restored increment mode and home address.
        send_byte(1'b1, 8'h55);
        send_byte(1'b1, 8'h56);
        read_chk("post_clr_0", 5'd0, 8'h55);
        read_chk("post_clr_1", 5'd1, 8'h56);
        check("ovr_sticky", {7'd0, overrun}, 8'h01);

        // Async reset mid-byte.
        strobe(1'b0, 4'h8);
        #2;
        RST = 1'b0;
        #1;
        check("arst_rd_data", rd_data, 8'h00);
        check("arst_display_on", {7'd0, display_on}, 8'h00);
        check("arst_four_bit", {7'd0, four_bit}, 8'h00);
        check("arst_backlight", {7'd0, backlight}, 8'h00);
        check("arst_busy", {7'd0, busy}, 8'h00);
        check("arst_overrun", {7'd0, overrun}, 8'h00);
        tick(2);
        RST = 1'b1;
        tick(2);
        strobe(1'b0, 4'h2);
        check("arst_boot_2", {7'd0, four_bit}, 8'h01);
        send_byte(1'b0, 8'h0C);
        check("arst_paired", {7'd0, display_on}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
